// File: rtl/fir4_pkg.sv
// Shared types and helpers for the 4-tap moving-sum decoder.
package fir4_pkg;

  localparam int W    = 16;
  localparam int TAPS = 4;

  typedef enum logic [1:0] {IDLE, RUN, FAULT} state_t;

  typedef struct packed {
    logic         ovf;
    logic [W-1:0] val;
  } sat_t;

  // Clamp a (W+4)-bit signed value into W-bit two's-complement range.
  function automatic sat_t sat_w(input logic signed [W+3:0] d);
    sat_t r;
    logic signed [W+3:0] hi, lo;
    hi    = {5'b00000, {(W-1){1'b1}}};
    lo    = {5'b11111, {(W-1){1'b0}}};
    r.ovf = 1'b0;
    r.val = d[W-1:0];
    if (d > hi) begin
      r.ovf = 1'b1;
      r.val = {1'b0, {(W-1){1'b1}}};
    end else if (d < lo) begin
      r.ovf = 1'b1;
      r.val = {1'b1, {(W-1){1'b0}}};
    end
    return r;
  endfunction

endpackage

// File: rtl/fir4_sum_decoder_if.sv
// Sum-stream in / reconstructed-sample out bundle for fir4_sum_decoder.
interface fir4_sum_decoder_if
  import fir4_pkg::*;
#(
  parameter int WD = W
);
  logic [WD+1:0] s;
  logic          s_valid;
  logic          clr;
  logic [WD-1:0] a;
  logic          a_valid;
  logic          ovf;
  logic          busy;

  modport master (output s, s_valid, clr, input a, a_valid, ovf, busy);
  modport slave  (input s, s_valid, clr, output a, a_valid, ovf, busy);
endinterface

// File: rtl/fir4_hist.sv
// TAPS-deep shift register of reconstructed samples; exposes the oldest entry.
module fir4_hist #(
  parameter int W    = 16,
  parameter int TAPS = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         en,
  input  logic         clr,
  input  logic [W-1:0] din,
  output logic [W-1:0] oldest
);
  logic [TAPS-1:0][W-1:0] h;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)   h <= '0;
    else if (clr) h <= '0;
    else if (en)  h <= {h[TAPS-2:0], din};
  end

  assign oldest = h[TAPS-1];
endmodule

// File: rtl/fir4_sum_decoder.sv
// Inverts a 4-tap moving-sum FIR: a[n] = s[n] - s[n-1] + a[n-4], with overflow trap.
module fir4_sum_decoder
  import fir4_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  fir4_sum_decoder_if.slave bus
);
  state_t              state;
  logic [W+1:0]        s_prev;
  logic [W-1:0]        h3;
  logic [W-1:0]        a_q;
  logic                a_valid_q;
  logic                ovf_q;
  logic                acc;
  logic signed [W+3:0] d;
  sat_t                r;

  // clr wins over a coincident sample, and FAULT swallows everything until clr.
  assign acc = bus.s_valid && !bus.clr && (state != FAULT);
  assign d   = {{2{bus.s[W+1]}}, bus.s} - {{2{s_prev[W+1]}}, s_prev} + {{4{h3[W-1]}}, h3};
  assign r   = sat_w(d);

  fir4_hist #(.W(W), .TAPS(TAPS)) u_hist (
    .clk    (clk),
    .reset  (reset),
    .en     (acc),
    .clr    (bus.clr),
    .din    (r.val),
    .oldest (h3)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      s_prev    <= '0;
      a_q       <= '0;
      a_valid_q <= 1'b0;
      ovf_q     <= 1'b0;
    end else if (bus.clr) begin
      state     <= IDLE;
      s_prev    <= '0;
      a_q       <= '0;
      a_valid_q <= 1'b0;
      ovf_q     <= 1'b0;
    end else begin
      a_valid_q <= acc;
      if (acc) begin
        s_prev <= bus.s;
        a_q    <= r.val;
        if (r.ovf) begin
          ovf_q <= 1'b1;
          state <= FAULT;
        end else begin
          state <= RUN;
        end
      end
    end
  end

  assign bus.a       = a_q;
  assign bus.a_valid = a_valid_q;
  assign bus.ovf     = ovf_q;
  assign bus.busy    = (state == RUN);
endmodule

// File: doc/fir4_sum_decoder.md
# fir4_sum_decoder

Inverse of the 4-tap signed moving-sum FIR. It takes the filter's (w+2)-bit sum stream and reconstructs the original w-bit input samples using a[n] = s[n] − s[n−1] + a[n−4]. It sits at the far end of a link carrying FIR output. Its job is to give the bench and downstream logic a lossless round-trip check of the FIR datapath. It also flags any sum stream that cannot have come from a zero-initialised 4-tap w-bit filter.

## Interface
- w, 16, width of the reconstructed two's-complement sample; the input sum is w+2 bits

- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low reset
- s  in  w+2  signed sum sample from the FIR
- s_valid  in  1  s is valid this cycle
- clr  in  1  synchronous clear; returns the block to IDLE with zeroed history
- a  out  w  signed reconstructed sample
- a_valid  out  1  a is valid this cycle (single-cycle pulse per sample)
- ovf  out  1  sticky flag: a reconstructed value exceeded the w-bit range
- busy  out  1  high in RUN state

## Operation
- State machine (enum in package):
  - IDLE → RUN on the first accepted s_valid.
  - RUN → FAULT when a reconstructed value is out of range.
  - FAULT → IDLE on clr.
  - RUN → IDLE on clr.
- A sample is accepted when s_valid=1 and the state is not FAULT. In FAULT, inputs are ignored.
- State registers:
  - s_prev, w+2 bits
  - history h0..h3, each w bits, holding the last four reconstructed samples; h3 is the oldest
- All of these registers are zero after reset or clr.
- Arithmetic for an accepted sample:
  - d = s − s_prev + h3, computed at w+4 bits, sign-extended
  - If d fits in [−2^(w−1), 2^(w−1)−1]: a ← d[w−1:0].
  - Otherwise: a ← saturated value (0x7FFF or 0x8000 for w=16), ovf ← 1, next state FAULT.
- On every accepted sample:
  - s_prev ← s
  - history shifts: h3←h2, h2←h1, h1←h0, h0←a (saturated value if overflowed)
- When s_valid=0, history and s_prev hold and a_valid=0. Gaps between samples do not disturb reconstruction.
- ovf stays set until reset or clr.
- clr has priority over s_valid in the same cycle. The sample presented with clr is discarded and no a_valid is produced.

## Timing
- Reset values:
  - a=0, a_valid=0, ovf=0, busy=0
  - state IDLE
  - all history and s_prev zero
- Latency: a/a_valid are registered and appear one cycle after the accepting edge. Full throughput of one sample per clock.
- The overflowing sample itself produces a_valid=1 with the saturated a and ovf=1 in the same cycle. After that, a_valid stays 0 until clr.
- The stream must begin at the FIR's first post-reset output, when the filter state is all zeros. A mid-stream start gives wrong values; this is not detected unless they overflow.
- Reset asserted mid-stream clears all registers immediately (asynchronously). Outputs go to their reset values within the same cycle.

## Structure
- Package fir4_pkg:
  - state_t enum {IDLE, RUN, FAULT}
  - localparam TAPS=4
  - function sat_w(d) that returns the clamped value plus an overflow bit
- One sub-module, fir4_hist: a parameterised TAPS-deep, w-bit shift register with shift enable and synchronous clear. It exposes its oldest entry.
- The top level holds the FSM, s_prev, the subtract/add datapath and the output registers.

## Test plan
- Ramp: after reset, s = 1,3,6,10,14,18 on consecutive cycles → a = 1,2,3,4,5,6, each one cycle later; ovf=0.
- Bubbles: the same stream with s_valid=0 for 3 cycles between every sample → identical a sequence, with one a_valid pulse per input.
- Round trip: 200 $random w=16 samples through the FIR and then this block, both reset together → a equals the FIR input delayed by the combined pipeline; zero mismatches.
- Overflow: first sample s=0x0_8000 (+32768) →
  - next cycle: a=0x7FFF, a_valid=1, ovf=1, state FAULT
  - following samples produce no a_valid
  - clr → IDLE with ovf=0, and the ramp test then passes again
- Negative extreme: s = −32768 then −65536 → a = 0x8000 then 0x8000 with no overflow.
- Reset mid-stream: assert reset during the ramp at sample 3 → outputs zero immediately; the ramp restarted after release decodes 1,2,3….
